// File: rtl/scr1_imem_arb.sv
// scr1_imem_arb: round-robin two-master arbiter for the imem bridge port
// with address-phase hold and an in-order ID FIFO for response routing.
module scr1_imem_arb #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    output logic              m0_req_ack,
    input  logic [ADDR_W-1:0] m0_addr,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_resp,
    input  logic              m1_req,
    output logic              m1_req_ack,
    input  logic [ADDR_W-1:0] m1_addr,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_resp,
    output logic              s_req,
    input  logic              s_req_ack,
    output logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_resp,
    output logic              arb_err
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [2**PW-1:0] fifo;
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             rr, hold, hold_id;
    logic             hold_ok, grant, full, push, pop, rsp_v, head;

    // a held master that dropped its request loses the hold immediately
    always_comb begin
        hold_ok    = hold & (hold_id ? m1_req : m0_req);
        grant      = hold_ok ? hold_id : (m0_req & m1_req) ? rr : m1_req;
        full       = count == CW'(DEPTH);
        s_req      = rst_n & (m0_req | m1_req) & ~full;
        s_addr     = !s_req ? '0 : grant ? m1_addr : m0_addr;
        push       = s_req & s_req_ack;
        m0_req_ack = push & ~grant;
        m1_req_ack = push & grant;
        rsp_v      = |s_resp;
        pop        = rsp_v & (count != '0);
        head       = fifo[rd_ptr];
        m0_resp    = (pop & ~head) ? s_resp : 2'b00;
        m1_resp    = (pop & head) ? s_resp : 2'b00;
    end

    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo    <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rr      <= 1'b0;
            hold    <= 1'b0;
            hold_id <= 1'b0;
            arb_err <= 1'b0;
        end else begin
            hold <= s_req & ~s_req_ack;
            if (s_req)
                hold_id <= grant;
            if (push) begin
                fifo[wr_ptr] <= grant;
                wr_ptr       <= wr_ptr + PW'(1);
                rr           <= ~grant;
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
            if ((hold & ~hold_ok) | (rsp_v & (count == '0)))
                arb_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_scr1_imem_arb.sv
// tb_scr1_imem_arb: directed scenario tests for the imem arbiter.
module tb_scr1_imem_arb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        m0_req = 1'b0, m1_req = 1'b0, s_req_ack = 1'b0;
    logic        m0_req_ack, m1_req_ack, s_req, arb_err;
    logic [31:0] m0_addr = 32'h100, m1_addr = 32'h800, s_addr, s_rdata = '0;
    logic [31:0] m0_rdata, m1_rdata;
    logic [1:0]  m0_resp, m1_resp, s_resp = 2'b00;
    int          checks = 0, failures = 0;

    scr1_imem_arb #(.DEPTH(2), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_req_ack(m0_req_ack), .m0_addr(m0_addr),
        .m0_rdata(m0_rdata), .m0_resp(m0_resp),
        .m1_req(m1_req), .m1_req_ack(m1_req_ack), .m1_addr(m1_addr),
        .m1_rdata(m1_rdata), .m1_resp(m1_resp),
        .s_req(s_req), .s_req_ack(s_req_ack), .s_addr(s_addr),
        .s_rdata(s_rdata), .s_resp(s_resp), .arb_err(arb_err)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic a, input logic b, input logic ack, input logic [1:0] r, input logic [31:0] d);
        @(negedge clk);
        m0_req = a; m1_req = b; s_req_ack = ack; s_resp = r; s_rdata = d;
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; m0_req = 0; m1_req = 0; s_req_ack = 0; s_resp = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0; m0_req = 1; s_req_ack = 1; s_resp = 2'b01;
        #1 checks++;
        if ({s_req, m0_req_ack, m1_req_ack, s_addr, m0_resp, m1_resp, arb_err} !== {3'b000, 32'h0, 4'b0000, 1'b0}) begin
            failures++; $display("FAIL reset_outputs got req=%b acks=%b%b addr=%h resp=%b/%b err=%b exp all zero", s_req, m0_req_ack, m1_req_ack, s_addr, m0_resp, m1_resp, arb_err);
        end
        apply_reset();
    endtask

    task automatic test_single();
        m0_addr = 32'h200;
        drive(1, 0, 1, 2'b00, 0); checks++;
        if ({s_req, m0_req_ack, m1_req_ack, s_addr} !== {3'b110, 32'h200}) begin
            failures++; $display("FAIL single_accept got %b%b%b %h exp 110 00000200", s_req, m0_req_ack, m1_req_ack, s_addr);
        end
        drive(0, 0, 0, 2'b00, 0); checks++;
        if (s_req !== 1'b0) begin failures++; $display("FAIL single_idle s_req got %b exp 0", s_req); end
        drive(0, 0, 0, 2'b01, 32'h00C58533); checks++;
        if ({m0_resp, m1_resp, m0_rdata, m1_rdata} !== {4'b0100, 32'h00C58533, 32'h00C58533}) begin
            failures++; $display("FAIL single_resp got %b/%b %h %h exp 01/00 00c58533", m0_resp, m1_resp, m0_rdata, m1_rdata);
        end
        drive(0, 0, 0, 2'b00, 0); checks++;
        if ({dut.count, arb_err} !== 3'b000) begin failures++; $display("FAIL single_drain count=%0d err=%b exp 0 0", dut.count, arb_err); end
        m0_addr = 32'h100;
    endtask

    task automatic test_round_robin();
        apply_reset();
        drive(1, 1, 1, 2'b00, 0); checks++;
        if ({s_req, m0_req_ack, m1_req_ack, s_addr} !== {3'b110, 32'h100}) begin failures++; $display("FAIL rr_g0 got %b%b%b %h exp 110 100", s_req, m0_req_ack, m1_req_ack, s_addr); end
        drive(1, 1, 1, 2'b00, 0); checks++;
        if ({s_req, m0_req_ack, m1_req_ack, s_addr} !== {3'b101, 32'h800}) begin failures++; $display("FAIL rr_g1 got %b%b%b %h exp 101 800", s_req, m0_req_ack, m1_req_ack, s_addr); end
        drive(1, 1, 1, 2'b01, 32'h11); checks++;
        if ({s_req, m0_req_ack, m1_req_ack, m0_resp, m1_resp} !== 7'b000_0100) begin failures++; $display("FAIL rr_full_r0 got %b%b%b %b/%b exp 000 01/00", s_req, m0_req_ack, m1_req_ack, m0_resp, m1_resp); end
        drive(1, 1, 1, 2'b01, 32'h22); checks++;
        if ({s_req, m0_req_ack, m1_req_ack, s_addr, m0_resp, m1_resp} !== {3'b110, 32'h100, 4'b0001}) begin failures++; $display("FAIL rr_g2_r1 got %b%b%b %h %b/%b exp 110 100 00/01", s_req, m0_req_ack, m1_req_ack, s_addr, m0_resp, m1_resp); end
        drive(1, 1, 1, 2'b01, 32'h33); checks++;
        if ({s_req, m0_req_ack, m1_req_ack, s_addr, m0_resp, m1_resp} !== {3'b101, 32'h800, 4'b0100}) begin failures++; $display("FAIL rr_g3_r2 got %b%b%b %h %b/%b exp 101 800 01/00", s_req, m0_req_ack, m1_req_ack, s_addr, m0_resp, m1_resp); end
        drive(0, 0, 0, 2'b01, 32'h44); checks++;
        if ({s_req, m0_resp, m1_resp} !== 5'b0_0001) begin failures++; $display("FAIL rr_r3 got %b %b/%b exp 0 00/01", s_req, m0_resp, m1_resp); end
        drive(0, 0, 0, 2'b00, 0); checks++;
        if ({dut.count, arb_err} !== 3'b000) begin failures++; $display("FAIL rr_drain count=%0d err=%b exp 0 0", dut.count, arb_err); end
    endtask

    task automatic test_hold();
        apply_reset();
        drive(0, 1, 0, 2'b00, 0); checks++;
        if ({s_req, m0_req_ack, m1_req_ack, s_addr} !== {3'b100, 32'h800}) begin failures++; $display("FAIL hold_start got %b%b%b %h exp 100 800", s_req, m0_req_ack, m1_req_ack, s_addr); end
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 0, 2'b00, 0); checks++;
            if ({s_req, m0_req_ack, m1_req_ack, s_addr} !== {3'b100, 32'h800}) begin failures++; $display("FAIL hold_keep%0d got %b%b%b %h exp 100 800", i, s_req, m0_req_ack, m1_req_ack, s_addr); end
        end
        drive(1, 1, 1, 2'b00, 0); checks++;
        if ({s_req, m0_req_ack, m1_req_ack, s_addr} !== {3'b101, 32'h800}) begin failures++; $display("FAIL hold_accept got %b%b%b %h exp 101 800", s_req, m0_req_ack, m1_req_ack, s_addr); end
        drive(1, 1, 1, 2'b00, 0); checks++;
        if ({s_req, m0_req_ack, m1_req_ack, s_addr} !== {3'b110, 32'h100}) begin failures++; $display("FAIL hold_next got %b%b%b %h exp 110 100", s_req, m0_req_ack, m1_req_ack, s_addr); end
        drive(0, 0, 0, 2'b01, 5); checks++;
        if ({m0_resp, m1_resp} !== 4'b0001) begin failures++; $display("FAIL hold_r1 got %b/%b exp 00/01", m0_resp, m1_resp); end
        drive(0, 0, 0, 2'b01, 6); checks++;
        if ({m0_resp, m1_resp} !== 4'b0100) begin failures++; $display("FAIL hold_r0 got %b/%b exp 01/00", m0_resp, m1_resp); end
        drive(0, 0, 0, 2'b00, 0); checks++;
        if (arb_err !== 1'b0) begin failures++; $display("FAIL hold_err got %b exp 0", arb_err); end
    endtask

    task automatic test_hold_drop();
        apply_reset();
        drive(0, 1, 0, 2'b00, 0);
        drive(1, 0, 0, 2'b00, 0); checks++;
        if ({s_req, s_addr, arb_err} !== {1'b1, 32'h100, 1'b0}) begin failures++; $display("FAIL drop_regrant got %b %h %b exp 1 100 0", s_req, s_addr, arb_err); end
        drive(0, 0, 0, 2'b00, 0); checks++;
        if (arb_err !== 1'b1) begin failures++; $display("FAIL drop_err got %b exp 1", arb_err); end
    endtask

    task automatic test_full();
        apply_reset();
        drive(1, 0, 1, 2'b00, 0);
        drive(1, 0, 1, 2'b00, 0); checks++;
        if (m0_req_ack !== 1'b1) begin failures++; $display("FAIL full_second_ack got %b exp 1", m0_req_ack); end
        drive(1, 0, 1, 2'b00, 0); checks++;
        if ({s_req, m0_req_ack, s_addr} !== {2'b00, 32'h0}) begin failures++; $display("FAIL full_block got %b%b %h exp 00 0", s_req, m0_req_ack, s_addr); end
        drive(1, 0, 1, 2'b01, 7); checks++;
        if ({s_req, m0_req_ack, m0_resp} !== 4'b0001) begin failures++; $display("FAIL full_nobypass got %b%b %b exp 00 01", s_req, m0_req_ack, m0_resp); end
        drive(1, 0, 1, 2'b00, 0); checks++;
        if ({s_req, m0_req_ack, s_addr} !== {2'b11, 32'h100}) begin failures++; $display("FAIL full_reopen got %b%b %h exp 11 100", s_req, m0_req_ack, s_addr); end
        drive(0, 0, 0, 2'b01, 8);
        drive(0, 0, 0, 2'b01, 9); checks++;
        if ({m0_resp, m1_resp} !== 4'b0100) begin failures++; $display("FAIL full_drain_resp got %b/%b exp 01/00", m0_resp, m1_resp); end
        drive(0, 0, 0, 2'b00, 0); checks++;
        if ({dut.count, arb_err} !== 3'b000) begin failures++; $display("FAIL full_drain count=%0d err=%b exp 0 0", dut.count, arb_err); end
    endtask

    task automatic test_error();
        apply_reset();
        drive(1, 0, 1, 2'b00, 0);
        drive(0, 0, 0, 2'b10, 32'hDEAD); checks++;
        if ({m0_resp, m1_resp, m0_rdata} !== {4'b1000, 32'hDEAD}) begin failures++; $display("FAIL err_resp got %b/%b %h exp 10/00 dead", m0_resp, m1_resp, m0_rdata); end
        drive(0, 0, 0, 2'b00, 0); checks++;
        if (arb_err !== 1'b0) begin failures++; $display("FAIL err_rdy_er got arb_err=%b exp 0", arb_err); end
        drive(0, 0, 0, 2'b01, 32'hBAD); checks++;
        if ({m0_resp, m1_resp} !== 4'b0000) begin failures++; $display("FAIL err_unexp_resp got %b/%b exp 00/00", m0_resp, m1_resp); end
        drive(0, 0, 0, 2'b00, 0); checks++;
        if (arb_err !== 1'b1) begin failures++; $display("FAIL err_unexp_flag got %b exp 1", arb_err); end
        drive(0, 0, 0, 2'b00, 0); checks++;
        if (arb_err !== 1'b1) begin failures++; $display("FAIL err_sticky got %b exp 1", arb_err); end
    endtask

    task automatic test_async_reset();
        apply_reset(); checks++;
        if (arb_err !== 1'b0) begin failures++; $display("FAIL ar_clear got %b exp 0", arb_err); end
        drive(1, 0, 1, 2'b00, 0);
        drive(1, 1, 1, 2'b01, 32'h55); checks++;
        if ({s_req, m1_req_ack, m0_resp} !== 4'b1101) begin failures++; $display("FAIL ar_pre got %b%b %b exp 11 01", s_req, m1_req_ack, m0_resp); end
        #1 rst_n = 1'b0;
        #1 checks++;
        if ({s_req, m0_req_ack, m1_req_ack, m0_resp, m1_resp, arb_err} !== 8'b0) begin failures++; $display("FAIL ar_drop got %b%b%b %b/%b %b exp all zero", s_req, m0_req_ack, m1_req_ack, m0_resp, m1_resp, arb_err); end
        @(negedge clk);
        rst_n = 1'b1; m0_req = 0; m1_req = 0; s_req_ack = 0; s_resp = 0;
        drive(0, 0, 0, 2'b01, 32'h66); checks++;
        if ({m0_resp, m1_resp} !== 4'b0000) begin failures++; $display("FAIL ar_stale_resp got %b/%b exp 00/00", m0_resp, m1_resp); end
        drive(0, 0, 0, 2'b00, 0); checks++;
        if (arb_err !== 1'b1) begin failures++; $display("FAIL ar_stale_err got %b exp 1", arb_err); end
        drive(1, 1, 1, 2'b00, 0); checks++;
        if ({s_req, m0_req_ack, m1_req_ack, s_addr} !== {3'b110, 32'h100}) begin failures++; $display("FAIL ar_favour_m0 got %b%b%b %h exp 110 100", s_req, m0_req_ack, m1_req_ack, s_addr); end
        drive(0, 0, 0, 2'b00, 0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_hold();
        test_hold_drop();
        test_full();
        test_error();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/scr1_imem_arb.md
Name: scr1_imem_arb

Overview:
- Two-master arbiter sharing the single instruction-memory port of the imem AHB bridge.
- Master 0 is the core fetch unit; master 1 is a secondary reader (debug program-buffer / trace fetch).
- Round-robin grant with address-phase hold.
- An in-order ID FIFO routes each bridge response back to the master that issued the request; supports up to DEPTH outstanding requests.

Parameters:
- DEPTH, 2, max outstanding accepted-but-unanswered requests (power of 2, ≥1)
- ADDR_W, 32, address width
- DATA_W, 32, read data width

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- m0_req  in  1  master 0 request
- m0_req_ack  out  1  master 0 request accepted
- m0_addr  in  ADDR_W  master 0 fetch address
- m0_rdata  out  DATA_W  master 0 read data
- m0_resp  out  2  master 0 response: 00 NOTRDY, 01 RDY_OK, 10 RDY_ER
- m1_req, m1_req_ack, m1_addr, m1_rdata, m1_resp  same as master 0, for master 1
- s_req  out  1  request to imem bridge
- s_req_ack  in  1  bridge accepted request
- s_addr  out  ADDR_W  address to bridge
- s_rdata  in  DATA_W  bridge read data
- s_resp  in  2  bridge response code
- arb_err  out  1  sticky protocol error flag

Behaviour:
- Reset (async, rst_n=0):
  - ID FIFO empty, count=0.
  - RR pointer favours m0.
  - hold=0, arb_err=0.
  - All outputs are combinational from this state: s_req=0, acks=0, m*_resp=00.
- Grant selection (comb):
  - If hold=1, grant = held ID.
  - Else, only one m*_req set: grant that master.
  - Else, both set: grant the master the RR pointer favours.
- Request path:
  - s_req = (m0_req|m1_req) & (count<DEPTH).
  - s_addr = granted master's addr; driven 0 when s_req=0.
  - m<g>_req_ack = s_req & s_req_ack & (grant==g); the other ack is 0.
- Address hold:
  - If s_req=1 and s_req_ack=0, set hold=1 and register the grant ID. The grant and s_addr must not switch until acceptance, even if the other master requests.
  - hold clears on acceptance.
  - If the held master drops m*_req before acceptance, clear hold (master protocol violation; arb_err set).
- Accept (s_req & s_req_ack):
  - Push grant ID into the FIFO.
  - RR pointer moves to favour the other master.
- Response (s_resp != 00):
  - Pop FIFO head; route s_resp/s_rdata to the head master.
  - The other master sees resp=00.
  - m*_rdata = s_rdata for both masters at all times; only resp is gated.
- Latency: request and response paths are 0 cycles combinational; grant/hold/FIFO state updates on the next rising clk.
- Simultaneous push and pop: count unchanged; wr/rd pointers both advance. Pop uses the head before the push.
- Full (count==DEPTH): s_req=0, both acks=0, no grant change. A response in the same cycle frees a slot only from the next cycle; there is no same-cycle bypass.
- Unexpected response (s_resp!=00 with count==0, including same-cycle-as-push): arb_err=1, response dropped, both m*_resp=00, FIFO unchanged.
- arb_err: sticky until reset.
- Pointers: log2(DEPTH) bits wrap naturally; count is log2(DEPTH)+1 bits.
- Reset mid-transaction: all outstanding IDs discarded. Later responses hit the empty-FIFO rule.

Test Plan:
- Single master: m0_req=1, addr=0x200, bridge acks cycle 0 and responds 01 with rdata=0x00C58533 two cycles later -> m0_req_ack pulses cycle 0, m0_resp=01 with that data, m1_resp=00, count returns to 0.
- Contention round-robin: m0_req and m1_req held high, bridge acks every cycle (addr 0x100/0x800) -> grants alternate m0,m1,m0,m1 starting at m0 after reset. Responses 01,01,01,01 route m0,m1,m0,m1 in issue order.
- Address hold: both requesting, grant m1, s_req_ack low 3 cycles -> s_addr stays m1_addr, m0_req_ack=0 throughout; on ack, m1 acked and the next grant goes to m0.
- Full: DEPTH=2, two accepted, no responses -> s_req=0 with m0_req=1. A response 01 in cycle N lets s_req reassert in cycle N+1, not N.
- Error path: m0 outstanding, bridge returns 10 -> m0_resp=10, arb_err stays 0. Then s_resp=01 with count=0 -> arb_err=1, both m*_resp=00.
- Async reset with 2 outstanding: rst_n low mid-cycle -> s_req, acks and m*_resp drop immediately. After release, the first response sets arb_err and m0 is favoured.
